// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: default widths, the
// sequential PC increment and the saturating step used by every counter.
package branch_target_buffer_pkg;

  localparam int          ADDR_W_DEF = 32;
  localparam logic [31:0] PC_INC     = 32'd4;

  // How a resolving branch changes the table this cycle.
  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_HIT   = 2'd1,
    UPD_ALLOC = 2'd2
  } upd_kind_e;

  // One saturating step of a counter up to 32 bits wide; inc and dec together
  // cancel out and leave the value unchanged.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] max_val,
                                           input logic        inc,
                                           input logic        dec);
    logic [31:0] nxt;
    nxt = cur;
    if (inc && !dec) begin
      nxt = (cur == max_val) ? cur : cur + 32'd1;
    end else if (dec && !inc) begin
      nxt = (cur == 32'd0) ? cur : cur - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup, EX resolve, clear and statistics signals between the CPU
// pipeline (master) and the branch target buffer (slave). There is no
// valid/ready handshake: lookups are answered in the same cycle and an EX
// resolve is accepted unconditionally on any clock edge where ex_valid is high.
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic              if_pc_dummy_unused_never;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_taken;
  logic [ADDR_W-1:0] if_pred_target;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              ex_mispredict;
  logic [ADDR_W-1:0] ex_redirect_pc;
  logic              clear;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken,
           ex_pred_target, clear,
    input  if_pred_taken, if_pred_target, ex_mispredict, ex_redirect_pc,
           stat_updates, stat_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken,
           ex_pred_target, clear,
    output if_pred_taken, if_pred_target, ex_mispredict, ex_redirect_pc,
           stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_target_buffer_sat_counter.sv
// Width-parametrised saturating up/down counter with synchronous clear and
// load (clear wins over load, load wins over counting). Used both for the
// per-entry direction counters and the statistics counters.
module branch_target_buffer_sat_counter
  import branch_target_buffer_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, then load, then a clamped step.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else begin
      count_d = W'(sat_step(32'(count_q), 32'(MAX_VAL), inc, dec));
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. IF looks up the fetch PC
// combinationally from registered state; EX resolution trains the entry,
// raises the flush request and supplies the correct next PC. Same-cycle
// lookup and update do not bypass: the lookup sees the old contents.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input logic                 clk,
  input logic                 reset,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(1 << (CNT_W - 1));

  // Table storage is flops so that lookups are purely combinational.
  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0]  if_idx;
  logic [TAG_W-1:0]  if_tag;
  logic              if_hit;
  logic              if_taken;
  logic [ADDR_W-1:0] if_target;

  logic [IDX_W-1:0]  ex_idx;
  logic [TAG_W-1:0]  ex_tag;
  logic              ex_hit;
  logic              ex_mispredict;
  logic [ADDR_W-1:0] ex_redirect;
  upd_kind_e         upd_kind;

  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  // Fetch-side lookup; a miss or a not-taken counter falls through to pc+4.
  always_comb begin
    if_idx    = bus.if_pc[IDX_W+1:2];
    if_tag    = bus.if_pc[ADDR_W-1:IDX_W+2];
    if_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    if_taken  = if_hit && cnt_q[if_idx][CNT_W-1];
    if_target = if_taken ? target_q[if_idx] : bus.if_pc + ADDR_W'(PC_INC);
  end

  // EX-side resolve: flush request, correct next PC and kind of table update.
  always_comb begin
    ex_idx        = bus.ex_pc[IDX_W+1:2];
    ex_tag        = bus.ex_pc[ADDR_W-1:IDX_W+2];
    ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_redirect   = bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_W'(PC_INC);
    ex_mispredict = bus.ex_valid &&
                    ((bus.ex_pred_taken != bus.ex_taken) ||
                     (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
    upd_kind = UPD_NONE;
    // A clear in the same cycle discards the training update.
    if (bus.ex_valid && !bus.clear) begin
      if (ex_hit) begin
        upd_kind = UPD_HIT;
      end else if (bus.ex_taken) begin
        upd_kind = UPD_ALLOC;
      end
    end
  end

  // Next table contents: clear-all, allocate on taken miss, retarget on taken hit.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
    end
    if (bus.clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (upd_kind == UPD_ALLOC) begin
      valid_d[ex_idx]  = 1'b1;
      tag_d[ex_idx]    = ex_tag;
      target_d[ex_idx] = bus.ex_target;
    end else if ((upd_kind == UPD_HIT) && bus.ex_taken) begin
      target_d[ex_idx] = bus.ex_target;
    end
  end

  // Table registers, emptied asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
      end
    end
  end

  // One direction counter per entry; allocation starts it at weakly taken.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_dir
    logic sel;
    assign sel = (ex_idx == IDX_W'(g));
    branch_target_buffer_sat_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (reset),
      .clr      (1'b0),
      .load     (sel && (upd_kind == UPD_ALLOC)),
      .load_val (CNT_WEAK_TAKEN),
      .inc      (sel && (upd_kind == UPD_HIT) && bus.ex_taken),
      .dec      (sel && (upd_kind == UPD_HIT) && !bus.ex_taken),
      .q        (cnt_q[g])
    );
  end

  // Statistics count every resolve, including ones dropped by clear.
  branch_target_buffer_sat_counter #(.W(STAT_W)) u_stat_upd (
    .clk      (clk),
    .rst      (reset),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (bus.ex_valid),
    .dec      (1'b0),
    .q        (stat_updates)
  );

  branch_target_buffer_sat_counter #(.W(STAT_W)) u_stat_mis (
    .clk      (clk),
    .rst      (reset),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (ex_mispredict),
    .dec      (1'b0),
    .q        (stat_mispredicts)
  );

  assign bus.if_pred_taken    = if_taken;
  assign bus.if_pred_target   = if_target;
  assign bus.ex_mispredict    = ex_mispredict;
  assign bus.ex_redirect_pc   = ex_redirect;
  assign bus.stat_updates     = stat_updates;
  assign bus.stat_mispredicts = stat_mispredicts;

endmodule
